msrv32_instruction_mux: RTL and testbench
=========================================

Name: msrv32_instruction_mux

Overview:
- Instruction-decode front end of the msrv32 RV32I multi-stage pipeline. Sits between instruction fetch and the decoder, register file and CSR file.
- On each clock it captures either the fetched instruction or, when flushing, a canonical NOP (ADDI x0,x0,0 = 32'h0000_0013).
- It slices the captured word into the standard RV32I fields for downstream stages.

Parameters:
- NOP_INSTR, 32'h0000_0013, word injected on flush and loaded at reset.
- XLEN, 32, instruction word width (fixed at 32; not intended to be overridden).

Ports:
- ms_riscv32_mp_clk_in  input  1  pipeline clock; all state updates on rising edge.
- ms_riscv32_mp_rst_in  input  1  synchronous, active-high reset.
- flush_in  input  1  1 = discard the fetched instruction and inject NOP_INSTR.
- ms_riscv32_mp_instr_in  input  32  instruction word from fetch.
- opcode_out  output  7  captured instr[6:0].
- funct3_out  output  3  captured instr[14:12].
- funct7_out  output  7  captured instr[31:25].
- rs1addr_out  output  5  captured instr[19:15].
- rs2addr_out  output  5  captured instr[24:20].
- rdaddr_out  output  5  captured instr[11:7].
- csr_addr_out  output  12  captured instr[31:20].
- instr_out  output  25  captured instr[31:7], passed to the immediate generator.

Behaviour:
- One internal 32-bit register, instr_q. All outputs are pure combinational slices of instr_q; there is no other state.
- Rising edge, priority order:
  - if ms_riscv32_mp_rst_in = 1: instr_q <= NOP_INSTR.
  - else if flush_in = 1: instr_q <= NOP_INSTR.
  - else: instr_q <= ms_riscv32_mp_instr_in.
- Reset state of the outputs: opcode_out=7'h13, every other output 0 (instr_out=25'h0, csr_addr_out=12'h000).
- Latency: exactly 1 cycle from input to outputs. Outputs stay stable for the whole cycle and only change on a clock edge.
- Input changes between edges have no effect on the outputs.
- Flush acts on the current edge only: the cycle after flush_in drops, the next fetched word is captured normally.
- Reset and flush together: reset wins. The result is the same value anyway (NOP).
- Reset asserted mid-stream: the next edge loads NOP regardless of flush_in or the instruction input.
- No field validation: illegal or unsupported opcodes pass through unchanged; decode-time traps are handled elsewhere.
- Field overlap is intentional: csr_addr_out = {funct7_out, rs2addr_out}, and instr_out contains every field except the opcode.
- X on ms_riscv32_mp_instr_in during flush or reset must not propagate; the captured value is NOP_INSTR.

Test Plan:
- Reset: hold rst=1 for 2 edges with instr_in=32'hFFFF_FFFF -> opcode=7'h13, all other outputs 0.
- Normal capture: rst=0, flush=0, instr_in=32'h0012_3456, one edge -> opcode=56, rd=08, funct3=3, rs1=04, rs2=01, funct7=00, csr=001, instr_out=25'h002468. Before that edge, outputs still show the previous value.
- CSR instruction: instr_in=32'h3420_2373 -> opcode=73, rd=06, funct3=2, rs1=00, rs2=02, funct7=1A, csr=342, instr_out=25'h684046.
- Flush: first capture 32'h0012_3456, then flush=1 with the same input for one edge -> opcode=13, all other fields 0. Drop flush -> the next edge captures the input again (opcode=56).
- Reset vs flush priority: rst=1 and flush=1 with instr_in=32'h3420_2373 -> NOP outputs. Release reset only -> still NOP while flush=1. Release flush -> the next edge gives opcode=73.
- Latency/stability: change instr_in mid-cycle across several values -> outputs change only at the following rising edge and reflect the value present at that edge.

Source files
------------

// File: rtl/msrv32_instruction_mux.sv
// Decode front end: registers the fetched instruction (or a NOP on flush/reset)
// and slices the captured word into RV32I fields for the decoder, register file and CSRs.
module msrv32_instruction_mux #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter int          XLEN      = 32
) (
  input  logic            ms_riscv32_mp_clk_in,
  input  logic            ms_riscv32_mp_rst_in,
  input  logic            flush_in,
  input  logic [XLEN-1:0] ms_riscv32_mp_instr_in,
  output logic [6:0]      opcode_out,
  output logic [2:0]      funct3_out,
  output logic [6:0]      funct7_out,
  output logic [4:0]      rs1addr_out,
  output logic [4:0]      rs2addr_out,
  output logic [4:0]      rdaddr_out,
  output logic [11:0]     csr_addr_out,
  output logic [XLEN-8:0] instr_out
);

  logic [XLEN-1:0] instr_d;
  logic [XLEN-1:0] instr_q;

  // The NOP path is a hard mux select, so an unknown fetch word during flush
  // or reset never reaches instr_q.
  always_comb begin
    instr_d = ms_riscv32_mp_instr_in;
    if (ms_riscv32_mp_rst_in || flush_in) begin
      instr_d = NOP_INSTR;
    end
  end

  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    instr_q <= instr_d;
  end

  // Field slices overlap on purpose: csr_addr is {funct7, rs2}, instr_out is everything above the opcode.
  assign opcode_out   = instr_q[6:0];
  assign rdaddr_out   = instr_q[11:7];
  assign funct3_out   = instr_q[14:12];
  assign rs1addr_out  = instr_q[19:15];
  assign rs2addr_out  = instr_q[24:20];
  assign funct7_out   = instr_q[31:25];
  assign csr_addr_out = instr_q[31:20];
  assign instr_out    = instr_q[XLEN-1:7];

endmodule

// File: tb/tb_msrv32_instruction_mux.sv
// Self-checking bench for msrv32_instruction_mux: directed scenarios plus a
// randomized run against a word-level capture model.
module tb_msrv32_instruction_mux;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic [11:0] csr;
  logic [24:0] iout;

  int compared;
  int mismatched;

  msrv32_instruction_mux dut (
    .ms_riscv32_mp_clk_in  (clk),
    .ms_riscv32_mp_rst_in  (rst),
    .flush_in              (flush),
    .ms_riscv32_mp_instr_in(instr),
    .opcode_out            (opcode),
    .funct3_out            (funct3),
    .funct7_out            (funct7),
    .rs1addr_out           (rs1),
    .rs2addr_out           (rs2),
    .rdaddr_out            (rd),
    .csr_addr_out          (csr),
    .instr_out             (iout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed outputs packed in a fixed order: opcode, funct3, funct7, rs1, rs2, rd, csr, instr_out.
  function automatic logic [68:0] observed();
    return {opcode, funct3, funct7, rs1, rs2, rd, csr, iout};
  endfunction

  // Reference field extraction using shift/mask arithmetic on the whole word.
  function automatic logic [68:0] fields(input logic [31:0] w);
    logic [6:0]  o;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [4:0]  ad;
    logic [11:0] c;
    logic [24:0] io;
    o  = 7'(w & 32'h7f);
    ad = 5'((w >> 7) & 32'h1f);
    f3 = 3'((w >> 12) & 32'h7);
    a1 = 5'((w >> 15) & 32'h1f);
    a2 = 5'((w >> 20) & 32'h1f);
    f7 = 7'((w >> 25) & 32'h7f);
    c  = 12'(w >> 20);
    io = 25'(w >> 7);
    return {o, f3, f7, a1, a2, ad, c, io};
  endfunction

  // Next captured word according to the edge priority rules.
  function automatic logic [31:0] next_word(input logic r, input logic f, input logic [31:0] w);
    if (r) return NOP;
    if (f) return NOP;
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [68:0] exp;
    exp = {7'h13, 3'h0, 7'h00, 5'h00, 5'h00, 5'h00, 12'h000, 25'h0};
    rst = 1'b1; flush = 1'b0; instr = 32'hFFFF_FFFF;
    for (int i = 0; i < 2; i++) begin
      tick();
      compared++;
      if (observed() !== exp) begin
        mismatched++;
        $display("FAIL reset_edge%0d: got %h expected %h", i, observed(), exp);
      end
    end
  endtask

  task automatic test_capture();
    logic [68:0] exp;
    rst = 1'b0; flush = 1'b0; instr = 32'h0012_3456;
    @(negedge clk);
    compared++;
    if (observed() !== fields(NOP)) begin
      mismatched++;
      $display("FAIL capture_before_edge: got %h expected %h", observed(), fields(NOP));
    end
    tick();
    exp = {7'h56, 3'h3, 7'h00, 5'h04, 5'h01, 5'h08, 12'h001, 25'h002468};
    compared++;
    if (observed() !== exp) begin
      mismatched++;
      $display("FAIL capture_normal: got %h expected %h", observed(), exp);
    end
  endtask

  task automatic test_csr();
    logic [68:0] exp;
    rst = 1'b0; flush = 1'b0; instr = 32'h3420_2373;
    tick();
    exp = {7'h73, 3'h2, 7'h1A, 5'h00, 5'h02, 5'h06, 12'h342, 25'h684046};
    compared++;
    if (observed() !== exp) begin
      mismatched++;
      $display("FAIL csr_fields: got %h expected %h", observed(), exp);
    end
  endtask

  task automatic test_flush();
    rst = 1'b0; flush = 1'b0; instr = 32'h0012_3456;
    tick();
    flush = 1'b1;
    tick();
    compared++;
    if (observed() !== fields(NOP)) begin
      mismatched++;
      $display("FAIL flush_nop: got %h expected %h", observed(), fields(NOP));
    end
    flush = 1'b0;
    tick();
    compared++;
    if (opcode !== 7'h56) begin
      mismatched++;
      $display("FAIL flush_release: got opcode %h expected 56", opcode);
    end
    // An unknown fetch word while flushing must still capture NOP.
    flush = 1'b1; instr = 32'hxxxx_xxxx;
    tick();
    compared++;
    if (observed() !== fields(NOP)) begin
      mismatched++;
      $display("FAIL flush_x_input: got %h expected %h", observed(), fields(NOP));
    end
    flush = 1'b0;
  endtask

  task automatic test_priority();
    rst = 1'b1; flush = 1'b1; instr = 32'h3420_2373;
    tick();
    compared++;
    if (observed() !== fields(NOP)) begin
      mismatched++;
      $display("FAIL prio_rst_flush: got %h expected %h", observed(), fields(NOP));
    end
    rst = 1'b0;
    tick();
    compared++;
    if (observed() !== fields(NOP)) begin
      mismatched++;
      $display("FAIL prio_flush_only: got %h expected %h", observed(), fields(NOP));
    end
    flush = 1'b0;
    tick();
    compared++;
    if (opcode !== 7'h73) begin
      mismatched++;
      $display("FAIL prio_release: got opcode %h expected 73", opcode);
    end
  endtask

  task automatic test_stability();
    logic [31:0] held;
    logic [31:0] w;
    held = 32'hA5A5_1234;
    rst = 1'b0; flush = 1'b0; instr = held;
    tick();
    for (int i = 0; i < 4; i++) begin
      w = $urandom;
      instr = w;
      #1;
      compared++;
      if (observed() !== fields(held)) begin
        mismatched++;
        $display("FAIL stable_midcycle%0d: got %h expected %h", i, observed(), fields(held));
      end
    end
    tick();
    compared++;
    if (observed() !== fields(w)) begin
      mismatched++;
      $display("FAIL stable_last_value: got %h expected %h", observed(), fields(w));
    end
  endtask

  task automatic test_random();
    logic [31:0] model;
    logic [31:0] w;
    logic        r;
    logic        f;
    for (int i = 0; i < 300; i++) begin
      r = ($urandom_range(0, 19) == 0);
      f = ($urandom_range(0, 4) == 0);
      w = $urandom;
      rst = r; flush = f; instr = w;
      model = next_word(r, f, w);
      tick();
      compared++;
      if (observed() !== fields(model)) begin
        mismatched++;
        $display("FAIL random_cycle%0d: got %h expected %h", i, observed(), fields(model));
      end
    end
    rst = 1'b0; flush = 1'b0;
  endtask

  initial begin
    compared = 0;
    mismatched = 0;
    rst = 1'b1; flush = 1'b0; instr = 32'h0;
    @(negedge clk);
    test_reset();
    test_capture();
    test_csr();
    test_flush();
    test_priority();
    test_stability();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
